// File: rtl/hex_scan.sv
// Time-multiplexed hex display scanner: shadow register, SHOW/GUARD digit FSM,
// leading-zero blanking and a per-frame completion pulse.
module hex_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    lz_en,
    output logic [4:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW    = $clog2(REFRESH_DIV);

    typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PW-1:0]           presc_q;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic                    frame_q;
    logic                    last_idx, terminal;

    assign last_idx = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign idx_d    = last_idx ? '0 : idx_q + IDX_W'(1);
    assign terminal = (presc_q == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GUARD;
            idx_q    <= '0;
            presc_q  <= '0;
            shadow_q <= '0;
            frame_q  <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            // Shadow capture is independent of the scan, so a load on the
            // terminal edge feeds the digit that follows the guard cycle.
            if (load) shadow_q <= data;
            case (state_q)
                GUARD: state_q <= SHOW;
                SHOW: begin
                    if (terminal) begin
                        state_q <= GUARD;
                        presc_q <= '0;
                        idx_q   <= idx_d;
                        frame_q <= last_idx;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                default: state_q <= GUARD;
            endcase
        end
    end

    logic [NUM_DIGITS-1:0] blank;
    logic                  zacc;
    logic [3:0]            nib;
    logic                  nib_blank;

    always_comb begin
        zacc      = 1'b1;
        blank     = '0;
        nib       = 4'h0;
        nib_blank = 1'b0;
        // Walk from the MS digit down; a digit blanks while everything above
        // and including it is still zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zacc     = zacc & (shadow_q[4*i +: 4] == 4'h0);
            blank[i] = lz_en & zacc & (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = shadow_q[4*i +: 4];
                nib_blank = blank[i];
            end
        end
        if (state_q == SHOW) begin
            an         = ~(NUM_DIGITS'(1) << idx_q);
            digit_code = nib_blank ? 5'h10 : {1'b0, nib};
        end else begin
            an         = '1;
            digit_code = 5'h10;
        end
    end

    assign frame_done = frame_q;

endmodule

// File: tb/tb_hex_scan.sv
// Directed bench for hex_scan (8 digits, 4-cycle refresh): walks whole frames
// position by position against a small expected-value model.
module tb_hex_scan;

    localparam int ND = 8;
    localparam int RD = 4;
    localparam int FRAME = ND * (RD + 1);

    logic          clk = 1'b0;
    logic          rst_n, load, lz_en;
    logic [31:0]   data;
    logic [4:0]    digit_code;
    logic [ND-1:0] an;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_data;
    logic        exp_lz;

    hex_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .lz_en(lz_en),
        .digit_code(digit_code), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs at frame position p (digit p/5, cycle p%5; cycle 4 is guard).
    task automatic check_pos(input int p);
        int dg, c;
        logic [31:0] upper, ec, ea;
        dg = p / (RD + 1);
        c  = p % (RD + 1);
        upper = exp_data >> (4 * dg);
        if (c == RD) begin
            ec = 32'h10;
            ea = 32'hFF;
        end else begin
            ea = {24'h0, ~(8'h01 << dg)};
            if (exp_lz && dg > 0 && upper == 32'h0) ec = 32'h10;
            else ec = upper & 32'hF;
        end
        chk($sformatf("code p%0d", p), {27'h0, digit_code}, ec);
        chk($sformatf("an p%0d", p), {24'h0, an}, ea);
        chk($sformatf("fd p%0d", p), {31'h0, frame_done}, {31'h0, p == FRAME - 1});
    endtask

    // One frame starting at the negedge of digit 0 cycle 0; optional load at ld_pos.
    task automatic run_frame(input int ld_pos, input logic [31:0] d1, input logic lz1);
        for (int p = 0; p < FRAME; p++) begin
            check_pos(p);
            if (p == ld_pos) begin
                load  = 1'b1;
                data  = d1;
                lz_en = lz1;
                @(negedge clk);
                load     = 1'b0;
                exp_data = d1;
                exp_lz   = lz1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; lz_en = 1'b0; data = 32'h0;
        exp_data = 32'h0; exp_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst an", {24'h0, an}, 32'hFF);
        chk("rst code", {27'h0, digit_code}, 32'h10);
        chk("rst fd", {31'h0, frame_done}, 32'h0);

        // Release and load on the very first edge.
        rst_n = 1'b1; load = 1'b1; data = 32'h1234ABCD;
        @(negedge clk);
        load = 1'b0; exp_data = 32'h1234ABCD;
        repeat (3) run_frame(-1, 32'h0, 1'b0);

        // Mid-SHOW load at digit 3 cycle 2, then a load on digit 1 terminal count.
        run_frame(3 * (RD + 1) + 2, 32'hFFFFFFFF, 1'b0);
        run_frame(1 * (RD + 1) + RD - 1, 32'h1234ABCD, 1'b0);

        // Leading-zero suppression patterns, loaded on the wrap edge.
        run_frame(FRAME - 1, 32'h000000A5, 1'b1);
        run_frame(FRAME - 1, 32'h00000000, 1'b1);
        run_frame(FRAME - 1, 32'h00F00100, 1'b1);
        run_frame(FRAME - 1, 32'h000000A5, 1'b0);
        run_frame(-1, 32'h0, 1'b0);

        // Asynchronous reset in the middle of digit 5.
        for (int p = 0; p <= 5 * (RD + 1) + 1; p++) begin
            check_pos(p);
            if (p != 5 * (RD + 1) + 1) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async an", {24'h0, an}, 32'hFF);
        chk("async code", {27'h0, digit_code}, 32'h10);
        chk("async fd", {31'h0, frame_done}, 32'h0);
        repeat (2) @(negedge clk);
        chk("hold fd", {31'h0, frame_done}, 32'h0);
        rst_n = 1'b1; lz_en = 1'b0;
        exp_data = 32'h0; exp_lz = 1'b0;
        @(negedge clk);
        run_frame(-1, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_scan.md
HEX_SCAN -- requirements
Module: hex_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed hex digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles each digit is displayed, legal range >= 2.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 load  input  1: one-cycle strobe that captures data into the shadow register.
REQ-006 data  input  4*NUM_DIGITS: value to display; nibble i drives digit i, digit 0 is the LSB.
REQ-007 lz_en  input  1: leading-zero suppression enable, level-sensitive.
REQ-008 digit_code  output  5: code for the downstream 7-segment decoder; 5'h00..5'h0F is a hex digit, 5'h10 is blank.
REQ-009 an  output  NUM_DIGITS: active-low digit enables, at most one bit low at any time.
REQ-010 frame_done  output  1: one-cycle pulse when a full scan of all digits completes.

Function
REQ-011 Shadow register: on a clk edge with load=1, capture data; with load=0, hold; there is no other write path.
REQ-012 Load mid-scan: a load does not reset the prescaler, digit index or FSM; the new nibble appears on digit_code in the cycle after the capture edge.
REQ-013 Two-state FSM:
  - SHOW: an = ~(1 << idx); digit_code = resolved nibble of digit idx.
  - GUARD: an = all ones; digit_code = 5'h10.
REQ-014 Prescaler in SHOW: counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1: go to GUARD, clear the prescaler, and advance idx.
  - idx advances as idx+1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 GUARD always lasts exactly one cycle, then goes to SHOW with idx unchanged; the prescaler does not count in GUARD.
REQ-016 Each digit period is REFRESH_DIV cycles in SHOW plus 1 GUARD cycle; one frame is NUM_DIGITS*(REFRESH_DIV+1) cycles.
REQ-017 frame_done pulses high for exactly the GUARD cycle entered on the idx wrap NUM_DIGITS-1 -> 0; it is low at all other times.
REQ-018 Leading-zero suppression, when lz_en=1:
  - Digit i > 0 is blank (digit_code 5'h10 in SHOW, its an bit still low) if shadow nibbles NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked.
  - lz_en=0 shows all nibbles.
REQ-019 The resolved code for a non-blank digit is {1'b0, nibble}; no other codes above 5'h10 are ever produced.
REQ-020 Outputs are glitch-free functions of registered state only (FSM, idx, shadow, lz_en); no combinational path from load or data to outputs.
REQ-021 Simultaneous load and SHOW->GUARD transition: both take effect on the same edge; the next SHOW digit uses the new shadow value.

Reset
REQ-022 While rst_n=0, and immediately on its assertion regardless of clk:
  - FSM = GUARD, idx = 0, prescaler = 0, shadow = 0.
  - an = all ones, digit_code = 5'h10, frame_done = 0.
REQ-023 After rst_n deasserts, the first clk edge moves the FSM to SHOW with idx=0; load is honoured from that first edge.
REQ-024 Reset mid-scan or mid-GUARD abandons the scan; no frame_done is produced for the interrupted frame.

Verification (NUM_DIGITS=8, REFRESH_DIV=4)
REQ-025 Reset then load data=32'h1234ABCD with lz_en=0:
  - digit_code sequence per SHOW period is D,C,B,A,4,3,2,1.
  - an = FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles.
  - each SHOW period is separated by one cycle of an=FF, digit_code=10.
REQ-026 Free-run for 3 frames: frame_done pulses exactly every 40 cycles, each pulse coincides with an=FF, and no cycle has two an bits low.
REQ-027 lz_en=1, data=32'h000000A5:
  - digits 0,1 show 5 and A.
  - digits 2..7 show code 10 with their an bit low.
  - data=0 shows only digit 0 = 0.
REQ-028 Load 32'hFFFFFFFF during SHOW of digit 3, cycle 2:
  - digit_code changes to F on the following cycle.
  - prescaler and idx timing are unchanged against a no-load run.
REQ-029 Assert rst_n=0 asynchronously mid-period of digit 5:
  - an=FF and digit_code=10 before the next clk edge.
  - after release, scanning restarts at digit 0 with shadow 0.
REQ-030 load coincident with the prescaler terminal count: the next SHOW digit displays the newly loaded nibble.
